// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand adder: folds each accepted operand into a
// carry-save pair, then resolves the pair with one carry-propagate add.
module csa_stream_accumulator #(
  parameter  int N  = 4,
  parameter  int M  = 8,
  localparam int W  = N + $clog2(M),
  localparam int CW = $clog2(M + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic [CW-1:0] out_count
);

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_RESOLVE,
    ST_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [W-1:0]  r_s;
  logic [W-1:0]  r_c;
  logic [CW-1:0] r_cnt;
  logic          r_out_valid;
  logic [W-1:0]  r_out_sum;
  logic [CW-1:0] r_out_count;

  logic [W-1:0]  w_x;
  logic [W-1:0]  w_s_nxt;
  logic [W-1:0]  w_maj;
  logic [W-1:0]  w_c_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_accept;
  logic          w_term;
  logic          w_drain;

  assign w_x       = {{(W-N){1'b0}}, in_data};
  assign w_s_nxt   = r_s ^ r_c ^ w_x;
  assign w_maj     = (r_s & r_c) | (r_s & w_x) | (r_c & w_x);
  // Carries weigh one bit higher; the top bit never carries because
  // W is sized for the worst-case total.
  assign w_c_nxt   = w_maj << 1;
  assign w_cnt_inc = r_cnt + CW'(1);

  assign in_ready  = (r_state == ST_ACCUM);
  assign w_accept  = in_valid & in_ready;
  assign w_term    = in_last | (w_cnt_inc == CW'(M));
  assign w_drain   = (r_state == ST_DONE) & out_ready;

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_ACCUM: begin
        if (w_accept && w_term) begin
          w_state_nxt = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_ACCUM;
        end
      end
      default: begin
        w_state_nxt = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s   <= '0;
      r_c   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_s   <= w_s_nxt;
      r_c   <= w_c_nxt;
      r_cnt <= w_cnt_inc;
    end else if (w_drain) begin
      r_s   <= '0;
      r_c   <= '0;
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
    end else if (r_state == ST_RESOLVE) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= r_s + r_c;
      r_out_count <= r_cnt;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Bench for csa_stream_accumulator: directed cases plus random streams
// on two configurations, checked against a plain-arithmetic sum model.
module tb_csa_stream_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Configuration A: N=4, M=8 (W=7, CW=4)
  logic       a_rst_n = 1'b0;
  logic       a_in_valid = 1'b0;
  logic       a_in_ready;
  logic [3:0] a_in_data = '0;
  logic       a_in_last = 1'b0;
  logic       a_out_valid;
  logic       a_out_ready = 1'b0;
  logic [6:0] a_out_sum;
  logic [3:0] a_out_count;

  // Configuration B: N=8, M=3 (W=10, CW=2)
  logic       b_rst_n = 1'b0;
  logic       b_in_valid = 1'b0;
  logic       b_in_ready;
  logic [7:0] b_in_data = '0;
  logic       b_in_last = 1'b0;
  logic       b_out_valid;
  logic       b_out_ready = 1'b0;
  logic [9:0] b_out_sum;
  logic [1:0] b_out_count;

  csa_stream_accumulator #(.N(4), .M(8)) u_a (
    .clk       (clk),
    .rst_n     (a_rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .in_last   (a_in_last),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_sum   (a_out_sum),
    .out_count (a_out_count)
  );

  csa_stream_accumulator #(.N(8), .M(3)) u_b (
    .clk       (clk),
    .rst_n     (b_rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_last   (b_in_last),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_sum   (b_out_sum),
    .out_count (b_out_count)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Model A: running total, operand count, pending result and its age.
  bit a_busy = 0;
  int a_age = 0, a_acc = 0, a_n = 0, a_xs = 0, a_xn = 0, a_sums = 0;

  task automatic cyc_a(input bit v, input logic [3:0] d, input bit l,
                       input bit r);
    @(negedge clk);
    check("a_in_ready", 32'(a_in_ready), 32'(!a_busy));
    check("a_out_valid", 32'(a_out_valid), 32'(a_busy && a_age >= 2));
    if (a_busy && a_age >= 2) begin
      check("a_out_sum", 32'(a_out_sum), a_xs);
      check("a_out_count", 32'(a_out_count), a_xn);
    end
    a_in_valid  = v;
    a_in_data   = d;
    a_in_last   = l;
    a_out_ready = r;
    if (a_busy) begin
      if (a_age >= 2 && r) a_busy = 0;
      else a_age++;
    end else if (v) begin
      a_acc += int'(d);
      a_n++;
      if (l || a_n == 8) begin
        a_busy = 1; a_age = 1;
        a_xs = a_acc; a_xn = a_n;
        a_acc = 0; a_n = 0;
        a_sums++;
      end
    end
  endtask

  task automatic rst_a(input int n);
    @(negedge clk);
    a_rst_n = 1'b0; a_in_valid = 1'b1; a_in_data = 4'd1;
    a_in_last = 1'b0; a_out_ready = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check("a_rst_rdy", 32'(a_in_ready), 1);
      check("a_rst_ovld", 32'(a_out_valid), 0);
      check("a_rst_sum", 32'(a_out_sum), 0);
      check("a_rst_cnt", 32'(a_out_count), 0);
    end
    a_rst_n = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b0;
    a_busy = 0; a_acc = 0; a_n = 0;
  endtask

  task automatic wait_res_a(input int s, input int k, input int lat);
    int i = 0;
    while (!a_out_valid && i < 8) begin
      cyc_a(0, 4'd0, 0, 0);
      i++;
    end
    check("a_latency", i, lat);
    check("a_sum_k", 32'(a_out_sum), s);
    check("a_cnt_k", 32'(a_out_count), k);
    cyc_a(0, 4'd0, 0, 1);
  endtask

  // Model B
  bit b_busy = 0;
  int b_age = 0, b_acc = 0, b_n = 0, b_xs = 0, b_xn = 0, b_sums = 0;

  task automatic cyc_b(input bit v, input logic [7:0] d, input bit l,
                       input bit r);
    @(negedge clk);
    check("b_in_ready", 32'(b_in_ready), 32'(!b_busy));
    check("b_out_valid", 32'(b_out_valid), 32'(b_busy && b_age >= 2));
    if (b_busy && b_age >= 2) begin
      check("b_out_sum", 32'(b_out_sum), b_xs);
      check("b_out_count", 32'(b_out_count), b_xn);
    end
    b_in_valid  = v;
    b_in_data   = d;
    b_in_last   = l;
    b_out_ready = r;
    if (b_busy) begin
      if (b_age >= 2 && r) b_busy = 0;
      else b_age++;
    end else if (v) begin
      b_acc += int'(d);
      b_n++;
      if (l || b_n == 3) begin
        b_busy = 1; b_age = 1;
        b_xs = b_acc; b_xn = b_n;
        b_acc = 0; b_n = 0;
        b_sums++;
      end
    end
  endtask

  initial begin
    fork
      begin : seq_a
        int s0, cyc;
        rst_a(2);
        // Full stream of maxima
        for (int i = 0; i < 8; i++) cyc_a(1, 4'd15, 0, 0);
        wait_res_a(120, 8, 2);
        // Early last, then single-operand sum
        cyc_a(1, 4'd5, 0, 0);
        cyc_a(0, 4'd9, 1, 0);
        cyc_a(1, 4'd9, 0, 0);
        cyc_a(1, 4'd3, 1, 0);
        wait_res_a(17, 3, 2);
        cyc_a(1, 4'd7, 1, 0);
        wait_res_a(7, 1, 2);
        // Backpressure with input pressure during the stall
        for (int i = 0; i < 8; i++) cyc_a(1, 4'd15, 0, 0);
        for (int i = 0; i < 7; i++) cyc_a(1, 4'd1, 0, 0);
        wait_res_a(120, 8, 0);
        cyc_a(1, 4'd2, 1, 0);
        wait_res_a(2, 1, 2);
        // Reset mid-accumulation discards the partial sum
        cyc_a(1, 4'd4, 0, 0);
        cyc_a(1, 4'd4, 0, 0);
        rst_a(1);
        cyc_a(1, 4'd6, 1, 0);
        wait_res_a(6, 1, 2);
        // Random streams
        s0 = a_sums; cyc = 0;
        while (a_sums - s0 < 1000 && cyc < 40000) begin
          cyc_a($urandom_range(0, 9) < 7, 4'($urandom),
                $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 6);
          cyc++;
        end
        check("a_rand_sums", 32'(a_sums - s0 >= 1000), 1);
        for (int i = 0; i < 6; i++) cyc_a(0, 4'd0, 0, 1);
      end
      begin : seq_b
        int s0, cyc;
        @(negedge clk);
        b_in_valid = 1'b1; b_in_data = 8'd9;
        repeat (2) @(negedge clk);
        check("b_rst_ovld", 32'(b_out_valid), 0);
        check("b_rst_sum", 32'(b_out_sum), 0);
        b_rst_n = 1'b1; b_in_valid = 1'b0;
        s0 = b_sums; cyc = 0;
        while (b_sums - s0 < 1000 && cyc < 40000) begin
          cyc_b($urandom_range(0, 9) < 7, 8'($urandom),
                $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 6);
          cyc++;
        end
        check("b_rand_sums", 32'(b_sums - s0 >= 1000), 1);
        for (int i = 0; i < 6; i++) cyc_b(0, 8'd0, 0, 1);
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
